// File: rtl/alu_pkg.sv
// Shared opcode constants and scheduler state encoding for the ALU scheduler slice.
package alu_pkg;
  localparam logic [3:0] OP_ADD        = 4'd0;
  localparam logic [3:0] OP_SUB        = 4'd1;
  localparam logic [3:0] OP_AND        = 4'd2;
  localparam logic [3:0] OP_OR         = 4'd3;
  localparam logic [3:0] OP_XOR        = 4'd4;
  localparam logic [3:0] OP_NOT        = 4'd5;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic any_req;

  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    any_req   = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    // Offset N wraps back to last_grant itself, so it is searched last.
    for (int off = 1; off <= N; off++) begin
      sum = {1'b0, last_grant} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any_req && req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant[gi] = any_req && (grant_idx == IW'(gi));
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Time-shares one combinational 8-bit ALU between N_REQ requesters with round-robin
// arbitration; each operation runs IDLE (accept) -> EXEC (ALU cycle) -> RESP (return).
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]   req_opcode,
  output logic [N_REQ-1:0]        resp_valid,
  input  logic [N_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]       resp_result,
  output logic                    resp_zero,
  output logic                    resp_carry,
  output logic                    resp_overflow,
  output logic                    resp_error,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_opcode,
  output logic                    alu_enable,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic                    alu_zero,
  input  logic                    alu_carry,
  input  logic                    alu_overflow
);
  localparam int IW = $clog2(N_REQ);

  state_t              state_reg, state_next;
  logic [IW-1:0]       last_grant_reg, grant_idx_reg;
  logic [DATA_W-1:0]   a_reg, b_reg, result_reg;
  logic [OP_W-1:0]     op_reg;
  logic                zero_reg, carry_reg, ovf_reg, err_reg;
  logic [N_REQ-1:0]    arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                op_legal;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign op_legal = (op_reg <= OP_W'(OP_LAST_LEGAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // req_ready depends only on state and req_valid, never on resp_ready.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    alu_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst) req_ready = arb_grant;
        if (|req_valid) state_next = EXEC;
      end
      EXEC: begin
        alu_enable = op_legal;
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready[grant_idx_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= IW'(N_REQ-1);
      grant_idx_reg  <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      result_reg     <= '0;
      zero_reg       <= 1'b0;
      carry_reg      <= 1'b0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (|req_valid) begin
          grant_idx_reg <= arb_idx;
          a_reg         <= req_a[int'(arb_idx)*DATA_W +: DATA_W];
          b_reg         <= req_b[int'(arb_idx)*DATA_W +: DATA_W];
          op_reg        <= req_opcode[int'(arb_idx)*OP_W +: OP_W];
        end
        EXEC: begin
          result_reg <= op_legal ? alu_result   : '0;
          zero_reg   <= op_legal ? alu_zero     : 1'b0;
          carry_reg  <= op_legal ? alu_carry    : 1'b0;
          ovf_reg    <= op_legal ? alu_overflow : 1'b0;
          err_reg    <= !op_legal;
        end
        RESP: if (resp_ready[grant_idx_reg]) last_grant_reg <= grant_idx_reg;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp_valid
    assign resp_valid[gi] = (state_reg == RESP) && (grant_idx_reg == IW'(gi));
  end

  assign resp_result   = result_reg;
  assign resp_zero     = zero_reg;
  assign resp_carry    = carry_reg;
  assign resp_overflow = ovf_reg;
  assign resp_error    = err_reg;
  assign alu_a         = a_reg;
  assign alu_b         = b_reg;
  assign alu_opcode    = op_reg;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural 8-bit ALU on the ALU side.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] req_opcode;
  logic [7:0]  resp_result, alu_a, alu_b, alu_result;
  logic        resp_zero, resp_carry, resp_overflow, resp_error;
  logic [3:0]  alu_opcode;
  logic        alu_enable, alu_zero, alu_carry, alu_overflow;

  int errors = 0;
  int checks = 0;

  alu_rr_scheduler #(.N_REQ(4), .DATA_W(8), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_carry(resp_carry),
    .resp_overflow(resp_overflow), .resp_error(resp_error),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal opcodes return junk so the scheduler must mask them.
  always_comb begin
    logic [8:0] wide;
    wide         = 9'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_result   = 8'd0;
    case (alu_opcode)
      OP_ADD: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = wide[7:0]; alu_carry = wide[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      OP_SUB: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = wide[7:0]; alu_carry = wide[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOT: alu_result = ~alu_a;
      default: begin
        alu_result = 8'hA5; alu_carry = 1'b1; alu_overflow = 1'b1;
      end
    endcase
    alu_zero = (alu_opcode > OP_LAST_LEGAL) ? 1'b1 : (alu_result == 8'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    req_a[i*8 +: 8]      = a;
    req_b[i*8 +: 8]      = b;
    req_opcode[i*4 +: 4] = op;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int exp_res [4] = '{50, 32, 118, 86};

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0;
    req_a = '0; req_b = '0; req_opcode = '0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_error", resp_error, 0);
    @(negedge clk); rst = 1'b0;

    // Single ADD from requester 0: ready at T, enable at T+1, response at T+2
    @(negedge clk);
    set_req(0, 8'd100, 8'd50, OP_ADD); req_valid = 4'b0001; #1;
    chk("t1_req_ready_T", req_ready, 4'b0001);
    chk("t1_alu_en_T", alu_enable, 0);
    @(negedge clk); req_valid = '0; #1;
    chk("t1_alu_en_T1", alu_enable, 1);
    chk("t1_alu_a", alu_a, 100);
    chk("t1_alu_b", alu_b, 50);
    chk("t1_req_ready_T1", req_ready, 0);
    chk("t1_resp_valid_T1", resp_valid, 0);
    step();
    chk("t1_resp_valid_T2", resp_valid, 4'b0001);
    chk("t1_result", resp_result, 150);
    chk("t1_error", resp_error, 0);
    chk("t1_alu_en_T2", alu_enable, 0);
    chk("t1_alu_a_hold", alu_a, 100);
    resp_ready = 4'b0001;
    step();
    chk("t1_resp_done", resp_valid, 0);

    // All four requesting continuously: grants rotate 0,1,2,3,0
    rst = 1'b1; #2; rst = 1'b0;
    set_req(0, 8'd100, 8'd50, OP_SUB);
    set_req(1, 8'd100, 8'd50, OP_AND);
    set_req(2, 8'd100, 8'd50, OP_OR);
    set_req(3, 8'd100, 8'd50, OP_XOR);
    resp_ready = 4'hF;
    @(negedge clk); req_valid = 4'hF; #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_grant_%0d", k), req_ready, 4'b0001 << (k % 4));
      step();
      chk($sformatf("t2_alu_en_%0d", k), alu_enable, 1);
      step();
      chk($sformatf("t2_resp_valid_%0d", k), resp_valid, 4'b0001 << (k % 4));
      chk($sformatf("t2_result_%0d", k), resp_result, exp_res[k % 4]);
      chk($sformatf("t2_req_ready_resp_%0d", k), req_ready, 0);
      if (k == 4) req_valid = '0;
      step();
    end

    // Requester 2: 0xFF + 0x01 wraps to zero with carry
    set_req(2, 8'hFF, 8'h01, OP_ADD); req_valid = 4'b0100; #1;
    chk("t3_req_ready", req_ready, 4'b0100);
    step();
    step();
    chk("t3_resp_valid", resp_valid, 4'b0100);
    chk("t3_result", resp_result, 0);
    chk("t3_zero", resp_zero, 1);
    chk("t3_carry", resp_carry, 1);
    chk("t3_overflow", resp_overflow, 0);
    req_valid = '0;
    step();

    // Backpressure on requester 1 while requester 0 waits
    resp_ready = '0;
    set_req(1, 8'd3, 8'd4, OP_ADD); req_valid = 4'b0010; #1;
    chk("t4_req_ready_1", req_ready, 4'b0010);
    @(negedge clk);
    set_req(0, 8'd10, 8'd20, OP_ADD); req_valid = 4'b0001; #1;
    chk("t4_req_ready_exec", req_ready, 0);
    resp_ready = 4'b1101;
    for (int j = 0; j < 5; j++) begin
      step();
      chk($sformatf("t4_hold_valid_%0d", j), resp_valid, 4'b0010);
      chk($sformatf("t4_hold_result_%0d", j), resp_result, 7);
      chk($sformatf("t4_hold_req_ready_%0d", j), req_ready, 0);
    end
    resp_ready = 4'b0010;
    step();
    chk("t4_req0_granted", req_ready, 4'b0001);
    chk("t4_resp_cleared", resp_valid, 0);
    step();
    chk("t4_alu_a_req0", alu_a, 10);
    req_valid = '0;
    step();
    chk("t4_resp_valid_0", resp_valid, 4'b0001);
    chk("t4_result_0", resp_result, 30);
    resp_ready = 4'b0001;
    step();
    chk("t4_idle", resp_valid, 0);

    // Illegal opcode from requester 3
    resp_ready = '0;
    set_req(3, 8'd5, 8'd6, 4'b1010); req_valid = 4'b1000; #1;
    chk("t5_req_ready", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0; #1;
    chk("t5_alu_en_exec", alu_enable, 0);
    chk("t5_alu_opcode", alu_opcode, 4'b1010);
    step();
    chk("t5_resp_valid", resp_valid, 4'b1000);
    chk("t5_error", resp_error, 1);
    chk("t5_result", resp_result, 0);
    chk("t5_zero", resp_zero, 0);
    chk("t5_carry", resp_carry, 0);
    chk("t5_overflow", resp_overflow, 0);
    chk("t5_alu_en_resp", alu_enable, 0);
    resp_ready = 4'b1000;
    step();
    chk("t5_idle", resp_valid, 0);

    // Reset during EXEC of requester 1
    resp_ready = '0;
    set_req(1, 8'd1, 8'd2, OP_ADD);
    set_req(2, 8'd7, 8'd7, OP_ADD);
    req_valid = 4'b0010; #1;
    chk("t6_req_ready_1", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b0110; #1;
    chk("t6_alu_en_exec", alu_enable, 1);
    rst = 1'b1; #1;
    chk("t6_rst_alu_en", alu_enable, 0);
    chk("t6_rst_alu_a", alu_a, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_result", resp_result, 0);
    step();
    chk("t6_no_resp", resp_valid, 0);
    rst = 1'b0; #1;
    chk("t6_regrant_1", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b0100; #1;
    step();
    chk("t6_resp_valid", resp_valid, 4'b0010);
    chk("t6_result", resp_result, 3);
    resp_ready = 4'b0110;
    step();
    chk("t6_next_grant_2", req_ready, 4'b0100);
    req_valid = '0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
